// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the seven-segment scan controller.
//   - SEG_BLANK  : all segments off (active-low, gfedcba)
//   - scan_state_t : per-slot scan phase (BLANK guard, then DRIVE)
//   - hex_to_seg : 0-F nibble to active-low gfedcba pattern
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low gfedcba; lower-case glyphs for b and d keep them distinct
  // from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
//   Purely combinational hex nibble to seven-segment lookup. A single
//   instance is shared by every digit of the scan controller.
//   Ports:
//     nibble_i  in  4  hex value to display
//     seg_o     out 7  segments gfedcba, active-low
// ---------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS common-anode seven-segment
//   digits sharing one decoder and one set of segment lines. A new display
//   value is accepted through a load/ready handshake and only becomes visible
//   at a frame boundary, so a frame never mixes old and new digits.
//
//   Each digit slot lasts SCAN_DIV clocks: BLANK_CYCLES of all-anodes-off
//   guard (anti-ghosting), then DRIVE for the rest of the slot.
//
//   Optional build macro:
//     LEADING_ZERO_BLANK_EN  suppress zero digits above the most significant
//                            non-zero digit of the committed display value
//                            (digit 0 always shown).
//
//   Ports:
//     clk        in   1             system clock
//     rst        in   1             asynchronous reset, active-high
//     load       in   1             request to capture value/digit_en
//     value      in   4*NUM_DIGITS  hex nibbles, nibble 0 = rightmost digit
//     digit_en   in   NUM_DIGITS    per-digit enable, 0 = digit dark
//     ready      out  1             1 = no pending update, load accepted
//     seg        out  7             segments gfedcba, active-low
//     an         out  NUM_DIGITS    anode selects, active-low
//     frame_tick out  1             one-cycle pulse after each frame boundary
//     dbg_state  out  scan_state_t  current scan phase (observation only)
// ---------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output scan_state_t             dbg_state
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  scan_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  // Committed display and pending update
  logic [VAL_W-1:0]       disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]  disp_en_q, disp_en_d;
  logic [VAL_W-1:0]       pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]  pend_en_q, pend_en_d;
  logic                   pend_valid_q, pend_valid_d;

  // Registered outputs
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic                   tick_q, tick_d;

  // Combinational helpers
  logic                   slot_end;
  logic                   frame_end;
  logic                   accept;
  logic                   commit;
  logic [3:0]             cur_nib;
  logic [6:0]             dec_seg;
  logic [NUM_DIGITS-1:0]  an_sel;
  logic [NUM_DIGITS-1:0]  lz_mask;
  logic                   digit_lit;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Handshake: the producer holds load with value/digit_en; a transfer
  // happens on any clock where load && ready. ready is low exactly while an
  // accepted update waits for the next frame boundary, and a load seen while
  // ready is low is dropped without touching the pending data.
  assign ready  = ~pend_valid_q;
  assign accept = load && ready;
  // accept and commit are mutually exclusive (commit needs pend_valid_q=1),
  // so a load on the boundary cycle waits for the following boundary.
  assign commit = frame_end && pend_valid_q;

  // One-hot select of the current digit, also used to pick its nibble.
  always_comb begin
    an_sel  = '0;
    cur_nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_q) begin
        an_sel[i] = 1'b1;
        cur_nib   = disp_val_q[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is suppressed while no non-zero
  // nibble has been seen at or above it. Digit 0 is never suppressed.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen       = seen | (disp_val_q[4*i +: 4] != 4'h0);
      lz_mask[i] = ~seen;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign digit_lit = |(an_sel & disp_en_q & ~lz_mask);

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    // Slot counter and digit index
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Scan phase follows the counter: BLANK at slot start, DRIVE after guard
    state_d = state_q;
    if (slot_end) begin
      state_d = BLANK;
    end else if (cnt_q == BLANK_LAST) begin
      state_d = DRIVE;
    end

    // Pending / display registers
    pend_val_d   = pend_val_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_en_d    = disp_en_q;
    if (accept) begin
      pend_val_d   = value;
      pend_en_d    = digit_en;
      pend_valid_d = 1'b1;
    end else if (commit) begin
      disp_val_d   = pend_val_q;
      disp_en_d    = pend_en_q;
      pend_valid_d = 1'b0;
    end

    // Outputs reflect this cycle's scan position on the next cycle
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (state_q == DRIVE && digit_lit) begin
      seg_d = dec_seg;
      an_d  = ~an_sel;
    end
    tick_d = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_en_q    <= '0;
      pend_val_q   <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_en_q    <= disp_en_d;
      pend_val_q   <= pend_val_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//   Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8,
//   BLANK_CYCLES=2 (one frame = 32 cycles). Expected observations are tagged
//   with the cycle number (cycle 0 = first cycle after reset release) and
//   queued by the driver; the monitor samples on the falling edge and checks
//   every queued entry whose tag matches the current cycle.
//   Honours LEADING_ZERO_BLANK_EN for the leading-zero frames.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;
  localparam int EW    = 31;

  // Segment patterns per digit, packed {d3, d2, d1, d0}
  localparam logic [27:0] SEGS_12AF = {7'h79, 7'h24, 7'h08, 7'h0E};
  localparam logic [27:0] SEGS_C5E0 = {7'h46, 7'h12, 7'h06, 7'h40};
  localparam logic [27:0] SEGS_0070 = {7'h40, 7'h40, 7'h78, 7'h40};
  localparam logic [27:0] SEGS_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] VIS_0070 = 4'b0011;
  localparam logic [3:0] VIS_0000 = 4'b0001;
`else
  localparam logic [3:0] VIS_0070 = 4'b1111;
  localparam logic [3:0] VIS_0000 = 4'b1111;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  scan_state_t dbg_state;

  always #5 clk = ~clk;

  logic [15:0] cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 16'd1;
  end

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .ready      (ready),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: [30:15] cycle, [14] check ready, [13] ready, [12] check an/seg,
  //        [11] frame_tick, [10:7] an, [6:0] seg
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic          mon_on;
  int            vectors;
  int            miscompares;

  task automatic chk(input string nm, input int c, input logic [15:0] act,
                     input logic [15:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, c, act, exp_v);
    end
  endtask

  task automatic push_ev(input int c, input logic m_rdy, input logic rdy,
                         input logic m_vis, input logic [3:0] a,
                         input logic [6:0] s);
    logic ft;
    ft = (c != 0) && (c % FRAME == 0);
    exp_q.push_back({16'(c), m_rdy, rdy, m_vis, ft, a, s});
  endtask

  task automatic push_rdy(input int c, input logic rdy);
    push_ev(c, 1'b1, rdy, 1'b0, 4'hF, 7'h7F);
  endtask

  task automatic push_vis(input int c, input logic [3:0] a, input logic [6:0] s);
    push_ev(c, 1'b0, 1'b0, 1'b1, a, s);
  endtask

  // Expected view of one frame starting at cycle s: each slot shows two
  // blank cycles, then six driven cycles; dark digits stay blank throughout.
  task automatic push_frame(input int s, input logic [3:0] vis,
                            input logic [27:0] segs);
    push_ev(s, 1'b0, 1'b0, 1'b0, 4'hF, 7'h7F);
    for (int d = 0; d < ND; d++) begin
      logic [3:0] a;
      logic [6:0] g;
      a = vis[d] ? ~(4'b0001 << d) : 4'hF;
      g = vis[d] ? segs[d*7 +: 7] : 7'h7F;
      push_vis(s + SD*d + 1, 4'hF, 7'h7F);
      push_vis(s + SD*d + 2, 4'hF, 7'h7F);
      push_vis(s + SD*d + 3, a, g);
      push_vis(s + SD*d + 7, a, g);
      if (d < ND - 1) push_vis(s + SD*d + 8, a, g);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        mon_e = exp_q[i];
        if (mon_e[30:15] == cyc) begin
          chk("frame_tick", int'(cyc), 16'(frame_tick), 16'(mon_e[11]));
          if (mon_e[14]) chk("ready", int'(cyc), 16'(ready), 16'(mon_e[13]));
          if (mon_e[12]) begin
            chk("an", int'(cyc), 16'(an), 16'(mon_e[10:7]));
            chk("seg", int'(cyc), 16'(seg), 16'(mon_e[6:0]));
          end
          exp_q.delete(i);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle(input int n);
    int guard;
    guard = 0;
    while (int'(cyc) != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("wait_cycle", n, cyc, 16'(n));
  endtask

  // Load is presented during cycle n and sampled at the edge ending it.
  task automatic drive_load(input int n, input logic [15:0] v, input logic [3:0] e);
    wait_cycle(n);
    load     = 1'b1;
    value    = v;
    digit_en = e;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_on      = 1'b0;
    rst         = 1'b1;
    load        = 1'b0;
    value       = '0;
    digit_en    = '0;

    // Power-up: dark, ready; update 12AF waits for boundary at cycle 31;
    // load of 3333 during the wait is ignored.
    push_ev(0, 1'b1, 1'b1, 1'b1, 4'hF, 7'h7F);
    push_vis(20, 4'hF, 7'h7F);
    push_rdy(3, 1'b1);
    push_rdy(4, 1'b0);
    push_rdy(31, 1'b0);
    push_rdy(32, 1'b1);
    push_rdy(63, 1'b1);
    push_frame(32, 4'hF, SEGS_12AF);
    push_frame(64, 4'hF, SEGS_12AF);

    #17;
    rst    = 1'b0;
    mon_on = 1'b1;

    drive_load(3, 16'h12AF, 4'hF);
    drive_load(10, 16'h3333, 4'hF);

    // Digit enables 0101: slots 1 and 3 stay dark, timing unchanged
    push_rdy(66, 1'b1);
    push_rdy(67, 1'b0);
    push_rdy(95, 1'b0);
    push_rdy(96, 1'b1);
    push_frame(96, 4'b0101, SEGS_12AF);
    drive_load(66, 16'h12AF, 4'b0101);

    // Load on the boundary cycle 127: not committed until cycle 159
    push_rdy(127, 1'b1);
    push_rdy(128, 1'b0);
    push_rdy(159, 1'b0);
    push_rdy(160, 1'b1);
    push_frame(128, 4'b0101, SEGS_12AF);
    push_frame(160, 4'hF, SEGS_C5E0);
    drive_load(127, 16'hC5E0, 4'hF);

    // Leading zeros: 0070, then 0000
    push_rdy(165, 1'b1);
    push_rdy(166, 1'b0);
    push_rdy(191, 1'b0);
    push_rdy(192, 1'b1);
    push_frame(192, VIS_0070, SEGS_0070);
    drive_load(165, 16'h0070, 4'hF);

    push_rdy(197, 1'b1);
    push_rdy(198, 1'b0);
    push_rdy(224, 1'b1);
    push_frame(224, VIS_0000, SEGS_0000);
    drive_load(197, 16'h0000, 4'hF);

    // Mid-frame reset with an update pending and digit 0 driven
    push_rdy(256, 1'b1);
    push_rdy(258, 1'b1);
    push_rdy(259, 1'b0);
    push_vis(261, 4'hE, 7'h40);
    drive_load(258, 16'hFFFF, 4'hF);
    wait_cycle(261);
    #2;
    mon_on = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst_seg", 261, 16'(seg), 16'h007F);
    chk("rst_an", 261, 16'(an), 16'h000F);
    chk("rst_ready", 261, 16'(ready), 16'h0001);
    chk("rst_frame_tick", 261, 16'(frame_tick), 16'h0000);
    chk("rst_state", 261, 16'(dbg_state), 16'(BLANK));
    chk("queue_drained", 261, 16'(exp_q.size()), 16'h0000);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
